// File: rtl/flag_register.sv
// CPU status flag register {C,S,Z} with per-flag write mask and branch-condition decode.
// Optional shadow save/restore of the flags is enabled by defining FLAG_SAVE_RESTORE_EN.
module flag_register #(
    parameter logic [2:0] RST_FLAGS = 3'b000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cf,
    input  logic       sf,
    input  logic       zf,
    input  logic       we,
    input  logic [2:0] wmask,
`ifdef FLAG_SAVE_RESTORE_EN
    input  logic       save,
    input  logic       restore,
`endif
    input  logic [2:0] cond_sel,
    output logic       cf_out,
    output logic       sf_out,
    output logic       zf_out,
    output logic [2:0] flags,
    output logic       cond_true
);

    localparam int C_BIT = 2;
    localparam int S_BIT = 1;
    localparam int Z_BIT = 0;

    logic [2:0] flags_q;
    logic [2:0] flags_d;
    logic [2:0] alu_flags;

    assign alu_flags = {cf, sf, zf};

`ifdef FLAG_SAVE_RESTORE_EN
    logic [2:0] shadow_q;
    logic [2:0] shadow_d;

    // Shadow reads the pre-edge flags, so save+restore together swaps the two registers.
    always_comb begin
        shadow_d = shadow_q;
        flags_d  = flags_q;
        if (we) begin
            flags_d = (flags_q & ~wmask) | (alu_flags & wmask);
        end
        if (save) begin
            shadow_d = flags_q;
        end
        if (restore) begin
            flags_d = shadow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= RST_FLAGS;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    always_comb begin
        flags_d = flags_q;
        if (we) begin
            flags_d = (flags_q & ~wmask) | (alu_flags & wmask);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= RST_FLAGS;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign cf_out = flags_q[C_BIT];
    assign sf_out = flags_q[S_BIT];
    assign zf_out = flags_q[Z_BIT];
    assign flags  = flags_q;

    // Decoded from the registered flags only; no path from the ALU inputs.
    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flags_q[Z_BIT];
            3'b010:  cond_true = ~flags_q[Z_BIT];
            3'b011:  cond_true = flags_q[C_BIT];
            3'b100:  cond_true = ~flags_q[C_BIT];
            3'b101:  cond_true = flags_q[S_BIT];
            3'b110:  cond_true = ~flags_q[S_BIT];
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_flag_register.sv
// Self-checking bench for flag_register: vector table through an expected-value queue,
// plus hand sequences for input glitches, the condition decode and optional save/restore.
module tb_flag_register;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cf = 1'b0, sf = 1'b0, zf = 1'b0;
    logic       we = 1'b0;
    logic [2:0] wmask = 3'b000;
    logic [2:0] cond_sel = 3'b000;
    logic       cf_out, sf_out, zf_out, cond_true;
    logic [2:0] flags;
`ifdef FLAG_SAVE_RESTORE_EN
    logic       save = 1'b0;
    logic       restore = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flag_register #(.RST_FLAGS(3'b000)) dut (
        .clk       (clk),
        .rst       (rst),
        .cf        (cf),
        .sf        (sf),
        .zf        (zf),
        .we        (we),
        .wmask     (wmask),
`ifdef FLAG_SAVE_RESTORE_EN
        .save      (save),
        .restore   (restore),
`endif
        .cond_sel  (cond_sel),
        .cf_out    (cf_out),
        .sf_out    (sf_out),
        .zf_out    (zf_out),
        .flags     (flags),
        .cond_true (cond_true)
    );

    typedef struct {
        logic       rst;
        logic       we;
        logic [2:0] wmask;
        logic [2:0] in_csz;
        logic [2:0] cond_sel;
        logic [2:0] exp_flags;
        logic       exp_cond;
    } vec_t;

    typedef struct {
        int         idx;
        logic [2:0] exp_flags;
        logic       exp_cond;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];

    function automatic logic cond_ref(input logic [2:0] sel, input logic [2:0] f);
        logic [7:0] lut;
        lut = {1'b0, ~f[1], f[1], ~f[2], f[2], ~f[0], f[0], 1'b1};
        return lut[sel];
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input logic [2:0] exp_f);
        check3({name, "_flags"}, flags, exp_f);
        check3({name, "_bits"}, {cf_out, sf_out, zf_out}, exp_f);
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst      = v.rst;
        we       = v.we;
        wmask    = v.wmask;
        {cf, sf, zf} = v.in_csz;
        cond_sel = v.cond_sel;
        e.idx = idx;
        e.exp_flags = v.exp_flags;
        e.exp_cond  = v.exp_cond;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty actual=0 required=1");
        end else begin
            got = sb.pop_front();
            if (flags !== got.exp_flags || {cf_out, sf_out, zf_out} !== got.exp_flags) begin
                failures++;
                $display("FAIL vec%0d_flags actual=%b/%b%b%b required=%b",
                         got.idx, flags, cf_out, sf_out, zf_out, got.exp_flags);
            end
            check1($sformatf("vec%0d_cond", got.idx), cond_true, got.exp_cond);
        end
    endtask

    task automatic sweep_cond(input string name, input logic [2:0] f);
        for (int s = 0; s < 8; s++) begin
            cond_sel = 3'(s);
            #1;
            check1($sformatf("%s_sel%0d", name, s), cond_true, cond_ref(3'(s), f));
        end
    endtask

    initial begin
        //          rst  we  wmask   in_csz  sel     exp     cond
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 3'b000, 3'b010, 3'b000, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 3'b111, 3'b010, 3'b000, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 3'b000, 3'b000, 3'b001, 3'b000, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b111, 3'b100, 3'b011, 3'b100, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 3'b111, 3'b101, 3'b001, 3'b101, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 3'b111, 3'b111, 3'b110, 3'b111, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, 3'b000, 3'b010, 3'b110, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 3'b111, 3'b000, 3'b111, 3'b110, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'b100, 3'b000, 3'b101, 3'b010, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 3'b111, 3'b111, 3'b100, 3'b111, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 3'b111, 3'b111, 3'b100, 3'b000, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 3'b011, 3'b011, 3'b011, 3'b011, 1'b0};

        for (int i = 0; i < 13; i++) begin
            apply_vec(i, vecs[i]);
        end
        check1("sb_drained", sb.size() == 0, 1'b1);

        // Flags now 011: inputs toggling mid-cycle must not reach the outputs.
        @(negedge clk);
        we = 1'b1;
        wmask = 3'b111;
        {cf, sf, zf} = 3'b100;
        #2;
        check_outputs("glitch_mid", 3'b011);
        {cf, sf, zf} = 3'b110;
        @(posedge clk);
        #1;
        check_outputs("glitch_edge", 3'b110);

        @(negedge clk);
        we = 1'b0;
        sweep_cond("cond110", 3'b110);
        @(negedge clk);
        we = 1'b1;
        {cf, sf, zf} = 3'b001;
        @(posedge clk);
        #1;
        check_outputs("w001", 3'b001);
        @(negedge clk);
        we = 1'b0;
        sweep_cond("cond001", 3'b001);

        // Long hold with changing inputs.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            {cf, sf, zf} = 3'($urandom_range(0, 7));
            wmask = 3'($urandom_range(0, 7));
        end
        @(posedge clk);
        #1;
        check_outputs("hold_long", 3'b001);

`ifdef FLAG_SAVE_RESTORE_EN
        @(negedge clk);
        we = 1'b1; wmask = 3'b111; {cf, sf, zf} = 3'b101;
        @(posedge clk); #1;
        check_outputs("sr_w101", 3'b101);
        @(negedge clk);
        we = 1'b0; save = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        save = 1'b0; we = 1'b1; {cf, sf, zf} = 3'b010;
        @(posedge clk); #1;
        check_outputs("sr_w010", 3'b010);
        @(negedge clk);
        restore = 1'b1; {cf, sf, zf} = 3'b111;
        @(posedge clk); #1;
        check_outputs("sr_restore", 3'b101);
        @(negedge clk);
        restore = 1'b0; {cf, sf, zf} = 3'b010;
        @(posedge clk); #1;
        @(negedge clk);
        we = 1'b0; save = 1'b1; restore = 1'b1;
        @(posedge clk); #1;
        check_outputs("sr_swap_flags", 3'b101);
        @(negedge clk);
        save = 1'b0;
        @(posedge clk); #1;
        check_outputs("sr_swap_shadow", 3'b010);
        @(negedge clk);
        restore = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0; restore = 1'b1;
        @(posedge clk); #1;
        check_outputs("sr_shadow_rst", 3'b000);
        @(negedge clk);
        restore = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
